// File: rtl/swap_pkg.sv
// swap_pkg: shared definitions for the swap initiator slice.
//   state_e        - 3-bit FSM state encoding
//   TimeoutDefault - default WAIT timeout in cycles
//   CntW           - width of the swap count and swaps_done
package swap_pkg;

  localparam int unsigned TimeoutDefault = 8;
  localparam int unsigned CntW           = 4;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StIssue = 3'd1,
    StWait  = 3'd2,
    StFin   = 3'd3,
    StErr   = 3'd4
  } state_e;

endpackage

// File: rtl/swap_timer.sv
// swap_timer: WAIT-phase watchdog counter.
// Ports:
//   clk     - clock, rising edge
//   rst     - asynchronous active-low reset
//   clr     - synchronous clear (dominates en)
//   en      - count one cycle
//   expired - high when this cycle's increment would reach TIMEOUT
module swap_timer
  import swap_pkg::*;
#(
  parameter int unsigned TIMEOUT = TimeoutDefault
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [7:0] Last = 8'(TIMEOUT - 1);

  logic [7:0] count_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else if (clr) begin
      count_q <= '0;
    end else if (en) begin
      count_q <= count_q + 8'd1;
    end
  end

  // Flagged one cycle early so the FSM leaves WAIT on the edge the count reaches TIMEOUT.
  assign expired = en && (count_q == Last);

endmodule

// File: rtl/swap_initiator.sv
// swap_initiator: issues a batch of n_swaps swap requests to a swap engine, one at a time,
// waiting for a done strobe after each, with a per-swap timeout.
// Ports:
//   clk        - clock, rising edge
//   rst        - asynchronous active-low reset
//   start      - batch request pulse, honoured only in IDLE or ERR
//   n_swaps    - swaps in the batch, latched on an accepted start
//   x          - one-cycle swap request strobe to the engine
//   done       - one-cycle completion strobe from the engine, honoured only in WAIT
//   busy       - high in ISSUE, WAIT and FIN
//   complete   - one-cycle pulse after the batch finishes
//   err        - sticky timeout flag, cleared by an accepted start
//   swaps_done - done strobes accepted in the current batch
module swap_initiator
  import swap_pkg::*;
#(
  parameter int unsigned TIMEOUT = TimeoutDefault
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [CntW-1:0] n_swaps,
  output logic            x,
  input  logic            done,
  output logic            busy,
  output logic            complete,
  output logic            err,
  output logic [CntW-1:0] swaps_done
);

  state_e          state_q;
  logic [CntW-1:0] count_q;  // latched batch size
  logic [CntW-1:0] sd_inc;
  logic            tmr_clr;
  logic            tmr_en;
  logic            tmr_expired;

  // Timer runs only while waiting; any other state holds it at zero so WAIT always starts at 0.
  assign tmr_clr = (state_q != StWait);
  assign tmr_en  = (state_q == StWait) && !done;
  assign sd_inc  = swaps_done + 4'd1;

  swap_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clr    (tmr_clr),
    .en     (tmr_en),
    .expired(tmr_expired)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      count_q    <= '0;
      x          <= 1'b0;
      busy       <= 1'b0;
      complete   <= 1'b0;
      err        <= 1'b0;
      swaps_done <= '0;
    end else begin
      x        <= 1'b0;
      complete <= 1'b0;
      unique case (state_q)
        StIdle, StErr: begin
          if (start) begin
            err        <= 1'b0;
            busy       <= 1'b1;
            count_q    <= n_swaps;
            swaps_done <= '0;
            if (n_swaps != '0) begin
              x       <= 1'b1;
              state_q <= StIssue;
            end else begin
              state_q <= StFin;
            end
          end
        end
        StIssue: begin
          state_q <= StWait;
        end
        StWait: begin
          // done beats a simultaneous timeout.
          if (done) begin
            swaps_done <= sd_inc;
            if (sd_inc == count_q) begin
              state_q <= StFin;
            end else begin
              x       <= 1'b1;
              state_q <= StIssue;
            end
          end else if (tmr_expired) begin
            err     <= 1'b1;
            busy    <= 1'b0;
            state_q <= StErr;
          end
        end
        StFin: begin
          complete <= 1'b1;
          busy     <= 1'b0;
          state_q  <= StIdle;
        end
        default: begin
          busy    <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_swap_initiator.sv
// tb_swap_initiator: directed table, hand sequences and randomized batches checked against an
// event-schedule model of the swap initiator.
module tb_swap_initiator;

  localparam int unsigned TO = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] n_swaps;
  logic       x;
  logic       done;
  logic       busy;
  logic       complete;
  logic       err;
  logic [3:0] swaps_done;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  swap_initiator #(
    .TIMEOUT(TO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .n_swaps   (n_swaps),
    .x         (x),
    .done      (done),
    .busy      (busy),
    .complete  (complete),
    .err       (err),
    .swaps_done(swaps_done)
  );

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    int n;
    int d;        // engine delay after sampling x; 0 = never answers
    int exp_cmp;  // edge of complete pulse, -1 = none
    int exp_erre; // edge err rises, -1 = none
    int exp_sd;
    int exp_x;
  } vec_t;

  vec_t vt[7];

  // Engine reacts to the actual x strobes; start re-pulsed at edge 2 while busy.
  task automatic run_directed(input int n, input int d, output int cmp_e, output int err_e,
                              output int xs, output int sd, output int err0, output int bz);
    int pend;
    pend  = -1;
    cmp_e = -1;
    err_e = -1;
    xs    = 0;
    err0  = 0;
    for (int e = 0; e < 90; e++) begin
      start   = (e == 0) || (e == 2 && n > 0);
      n_swaps = (e == 0) ? n[3:0] : 4'd7;
      done    = (pend == e);
      step();
      if (e == 0) err0 = err;
      if (x) begin
        xs++;
        if (d > 0) pend = e + 1 + d;
      end
      if (complete && cmp_e < 0) cmp_e = e;
      if (err && err_e < 0) err_e = e;
    end
    start = 1'b0;
    done  = 1'b0;
    sd    = swaps_done;
    bz    = busy;
  endtask

  // ---------------- event-schedule model ----------------
  int dly[16];
  int issue_e[$];
  int done_e[$];
  int drv_done[$];

  function automatic bit in_q(input int q[$], input int v);
    foreach (q[i]) if (q[i] == v) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int cnt_le(input int q[$], input int v);
    int c = 0;
    foreach (q[i]) if (q[i] <= v) c++;
    return c;
  endfunction

  // Edges are relative to the accepting start edge (0). Each request is raised on edge t,
  // sampled by the engine on t+1, answered on t+1+d; an answer later than TO times out.
  task automatic model(input int n, output int cmp_e, output int err_e, output int bend,
                       output int rend);
    int t;
    int w;
    issue_e.delete();
    done_e.delete();
    drv_done.delete();
    cmp_e = -1;
    err_e = -1;
    if (n == 0) begin
      cmp_e = 1;
    end else begin
      t = 0;
      for (int k = 0; k < n; k++) begin
        w = t + 1;
        issue_e.push_back(t);
        drv_done.push_back(w + dly[k]);
        if (dly[k] <= int'(TO)) begin
          done_e.push_back(w + dly[k]);
          t = w + dly[k];
          if (k == n - 1) cmp_e = t + 1;
        end else begin
          err_e = w + int'(TO);
          break;
        end
      end
    end
    bend = (cmp_e >= 0) ? cmp_e : err_e;
    rend = bend + 2;
    foreach (drv_done[i]) if (drv_done[i] + 2 > rend) rend = drv_done[i] + 2;
  endtask

  initial begin
    int cmp_e, err_e, xs, sd, err0, bz;

    vt[0] = '{n: 1,  d: 3, exp_cmp: 5,  exp_erre: -1, exp_sd: 1,  exp_x: 1};
    vt[1] = '{n: 3,  d: 3, exp_cmp: 13, exp_erre: -1, exp_sd: 3,  exp_x: 3};
    vt[2] = '{n: 2,  d: 0, exp_cmp: -1, exp_erre: 9,  exp_sd: 0,  exp_x: 1};
    vt[3] = '{n: 0,  d: 3, exp_cmp: 1,  exp_erre: -1, exp_sd: 0,  exp_x: 0};
    vt[4] = '{n: 15, d: 3, exp_cmp: 61, exp_erre: -1, exp_sd: 15, exp_x: 15};
    vt[5] = '{n: 2,  d: 8, exp_cmp: 19, exp_erre: -1, exp_sd: 2,  exp_x: 2};
    vt[6] = '{n: 1,  d: 9, exp_cmp: -1, exp_erre: 9,  exp_sd: 0,  exp_x: 1};

    // Reset state
    rst     = 1'b1;
    start   = 1'b0;
    done    = 1'b0;
    n_swaps = '0;
    #2 rst = 1'b0;
    step();
    step();
    chk("reset x", x, 0);
    chk("reset busy", busy, 0);
    chk("reset complete", complete, 0);
    chk("reset err", err, 0);
    chk("reset swaps_done", swaps_done, 0);
    rst = 1'b1;

    // Directed table; the first start lands on the first edge after reset release
    for (int i = 0; i < 7; i++) begin
      run_directed(vt[i].n, vt[i].d, cmp_e, err_e, xs, sd, err0, bz);
      chk($sformatf("vec%0d complete edge", i), cmp_e, vt[i].exp_cmp);
      chk($sformatf("vec%0d err edge", i), err_e, vt[i].exp_erre);
      chk($sformatf("vec%0d swaps_done", i), sd, vt[i].exp_sd);
      chk($sformatf("vec%0d x pulses", i), xs, vt[i].exp_x);
      chk($sformatf("vec%0d err cleared by start", i), err0, 0);
      chk($sformatf("vec%0d busy at end", i), bz, 0);
    end

    // Reset in WAIT of a 4-swap batch, one swap already done
    start   = 1'b1;
    n_swaps = 4'd4;
    step();
    start = 1'b0;
    step();
    step();
    step();
    done = 1'b1;
    step();
    done = 1'b0;
    chk("midrst x reissued", x, 1);
    chk("midrst swaps_done before", swaps_done, 1);
    step();
    step();
    chk("midrst busy in wait", busy, 1);
    #2 rst = 1'b0;
    #1;
    chk("midrst x", x, 0);
    chk("midrst busy", busy, 0);
    chk("midrst swaps_done", swaps_done, 0);
    #2 rst = 1'b1;
    start   = 1'b1;
    n_swaps = 4'd1;
    step();
    start = 1'b0;
    chk("post-rst start busy", busy, 1);
    chk("post-rst start x", x, 1);
    step();
    step();
    step();
    done = 1'b1;
    step();
    done = 1'b0;
    step();
    chk("post-rst complete", complete, 1);
    chk("post-rst swaps_done", swaps_done, 1);

    // Randomized batches with spurious starts while busy and spurious dones outside WAIT
    for (int b = 0; b < 40; b++) begin
      int n, ecmp, eerr, bend, rend;
      n = $urandom_range(0, 15);
      for (int k = 0; k < 16; k++)
        dly[k] = ($urandom_range(0, 9) == 0) ? int'($urandom_range(TO + 1, TO + 3))
                                             : int'($urandom_range(1, TO));
      model(n, ecmp, eerr, bend, rend);
      for (int e = 0; e <= rend; e++) begin
        start   = (e == 0) || (e <= bend && $urandom_range(0, 5) == 0);
        n_swaps = (e == 0) ? 4'(n) : 4'($urandom_range(0, 15));
        done    = in_q(drv_done, e) || ((e == 0 || e > bend) && $urandom_range(0, 3) == 0);
        step();
        chk("rnd x", x, int'(in_q(issue_e, e)));
        chk("rnd complete", complete, int'(e == ecmp));
        chk("rnd err", err, int'(eerr >= 0 && e >= eerr));
        chk("rnd busy", busy, int'(e < bend));
        chk("rnd swaps_done", swaps_done, cnt_le(done_e, e));
      end
      start = 1'b0;
      done  = 1'b0;
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/swap_initiator.md
SWAP_INITIATOR -- requirements
Module: swap_initiator

Interface
REQ-001 The module SHALL have parameter TIMEOUT, default 8, giving the maximum cycles WAIT tolerates without done (legal 4..255).
REQ-002 The module SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The module SHALL have port rst, input, 1, reset, asynchronous and active-low.
REQ-004 The module SHALL have port start, input, 1, request pulse; sampled only in IDLE or ERR.
REQ-005 The module SHALL have port n_swaps, input, 4, number of swap operations requested; latched when start is accepted.
REQ-006 The module SHALL have port x, output, 1, swap-request strobe toward the swap engine.
REQ-007 The module SHALL have port done, input, 1, completion strobe from the swap engine (one-cycle high per swap).
REQ-008 The module SHALL have port busy, output, 1, high in ISSUE, WAIT and FIN.
REQ-009 The module SHALL have port complete, output, 1, one-cycle pulse when the whole batch finishes.
REQ-010 The module SHALL have port err, output, 1, sticky timeout flag.
REQ-011 The module SHALL have port swaps_done, output, 4, count of done strobes accepted in the current batch.

Function
REQ-012 The state machine SHALL have states IDLE, ISSUE, WAIT, FIN and ERR; all outputs registered or decoded from state only.
REQ-013 In IDLE or ERR, start=1 with n_swaps!=0 SHALL latch n_swaps, clear swaps_done and err, clear the timer, and enter ISSUE.
REQ-014 In IDLE or ERR, start=1 with n_swaps=0 SHALL clear err and enter FIN directly, never asserting x.
REQ-015 ISSUE SHALL drive x=1 for exactly one cycle, then enter WAIT with timer=0; x SHALL be 0 in every other state.
REQ-016 In WAIT, done=1 SHALL increment swaps_done; if the new value equals the latched count, the FSM SHALL enter FIN, else ISSUE.
REQ-017 In WAIT, the timer SHALL increment each cycle done=0; reaching TIMEOUT SHALL enter ERR.
REQ-018 done=1 and timer reaching TIMEOUT on the same edge SHALL be resolved in favour of done.
REQ-019 FIN SHALL assert complete for one cycle, then return to IDLE; swaps_done SHALL hold its value until the next accepted start.
REQ-020 ERR SHALL hold err=1 and busy=0 until an accepted start.
REQ-021 start while busy=1 SHALL be ignored with no side effect.
REQ-022 done outside WAIT SHALL be ignored and SHALL NOT change swaps_done.
REQ-023 Against an engine answering done three edges after sampling x, one batch SHALL take 4*n_swaps+1 cycles from the start edge to the complete pulse.
REQ-024 swaps_done SHALL never wrap, since it cannot exceed the latched count (max 15).

Reset
REQ-025 rst=0 SHALL immediately force state IDLE, x=0, busy=0, complete=0, err=0, swaps_done=0, timer=0 and latched count=0, including mid-batch.
REQ-026 The first start SHALL be accepted on the first rising edge after rst deasserts.

Structure
REQ-027 A shared package swap_pkg SHALL hold the state encoding (3-bit), the default TIMEOUT constant and the count width (4).
REQ-028 The timeout counter SHALL be a sub-module swap_timer with ports clk, rst, clr, en and expired, parameterised by TIMEOUT.
REQ-029 Total RTL SHALL be a single FSM plus datapath in swap_initiator, with swap_timer instantiated once.

Verification
REQ-030 Scenario: n_swaps=1, start pulse, model engine with done three edges after x -> one x pulse, complete 5 cycles after start, swaps_done=1.
REQ-031 Scenario: n_swaps=3 -> exactly three x pulses 4 cycles apart, complete at cycle 13, swaps_done=3, err=0.
REQ-032 Scenario: n_swaps=2, engine never answers, TIMEOUT=8 -> one x pulse, err=1 eight cycles into WAIT, busy=0, no complete; a new start clears err.
REQ-033 Scenario: n_swaps=0 start -> no x, complete pulse on the next cycle, swaps_done=0.
REQ-034 Scenario: rst pulled low during WAIT of a 4-swap batch -> x, busy and swaps_done are 0 within the same cycle, IDLE after release.
REQ-035 Scenario: start re-pulsed while busy, plus a spurious done in IDLE -> batch unaffected, swaps_done unchanged.
